// File: rtl/mips_mem_pkg.sv
// Shared constants and types for the IF/DM single-port memory arbiter.
package mips_mem_pkg;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_DM = 1'b1;

  localparam int unsigned AW_DEF     = 10;
  localparam int unsigned DW_DEF     = 32;
  localparam int unsigned RD_LAT_MAX = 4;

  typedef struct packed {
    logic valid;
    logic owner;
  } rsp_tag_t;

endpackage

// File: rtl/rsp_tag_pipe.sv
// Read-response owner tracking: a DEPTH-stage {valid, owner} shift register
// whose IF-owned entries are invalidated by flush.
module rsp_tag_pipe
  import mips_mem_pkg::*;
#(
  parameter int unsigned DEPTH = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push_valid,
  input  logic push_owner,
  input  logic flush,
  output logic tail_valid_c,
  output logic tail_owner_c
);

  rsp_tag_t stage [DEPTH];
  logic     push_keep_c;

  assign push_keep_c = push_valid & ~(flush & (push_owner == OWN_IF));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) stage[i] <= '0;
    end else begin
      stage[0] <= '{valid: push_keep_c, owner: push_owner};
      for (int i = 1; i < int'(DEPTH); i++) begin
        stage[i].valid <= stage[i-1].valid & ~(flush & (stage[i-1].owner == OWN_IF));
        stage[i].owner <= stage[i-1].owner;
      end
    end
  end

  // Flush also kills an IF response sitting at the tail in the same cycle.
  assign tail_valid_c = stage[DEPTH-1].valid & ~(flush & (stage[DEPTH-1].owner == OWN_IF));
  assign tail_owner_c = stage[DEPTH-1].owner;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between fetch (IF) and load/store (DM).
// Define ARB_STATS_EN to add saturating grant/conflict statistics outputs.
module mem_port_arbiter
  import mips_mem_pkg::*;
#(
  parameter int unsigned AW         = AW_DEF,
  parameter int unsigned DW         = DW_DEF,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_gnt,
  output logic          dm_rvalid,
  output logic [DW-1:0] dm_rdata,
  input  logic          flush,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
`ifdef ARB_STATS_EN
  ,
  output logic [31:0]   stat_if_grants,
  output logic [31:0]   stat_dm_grants,
  output logic [31:0]   stat_conflicts
`endif
);

  localparam int unsigned SW    = $clog2(STARVE_MAX + 1);
  // Out-of-range latencies clamp into the supported 1..RD_LAT_MAX window.
  localparam int unsigned DEPTH = (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX :
                                  ((RD_LAT < 1) ? 1 : RD_LAT);

  logic [SW-1:0] starve_cnt;
  logic          starved_c;
  logic          push_valid_c;
  logic          push_owner_c;
  logic          tail_valid_c;
  logic          tail_owner_c;

  assign starved_c = (starve_cnt == SW'(STARVE_MAX));

  // DM wins contested cycles until IF has waited STARVE_MAX cycles in a row.
  always_comb begin
    if_gnt = 1'b0;
    dm_gnt = 1'b0;
    if (rst_n) begin
      if (if_req && !flush && (!dm_req || starved_c)) begin
        if_gnt = 1'b1;
      end else if (dm_req) begin
        dm_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    mem_en    = if_gnt | dm_gnt;
    mem_we    = dm_gnt & dm_we;
    mem_addr  = '0;
    mem_wdata = '0;
    if (dm_gnt) begin
      mem_addr  = dm_addr;
      mem_wdata = dm_wdata;
    end else if (if_gnt) begin
      mem_addr  = if_addr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (if_gnt || !if_req || flush) begin
      starve_cnt <= '0;
    end else if (!starved_c) begin
      starve_cnt <= starve_cnt + SW'(1);
    end
  end

  assign push_valid_c = if_gnt | (dm_gnt & ~dm_we);
  assign push_owner_c = dm_gnt ? OWN_DM : OWN_IF;

  rsp_tag_pipe #(
    .DEPTH (DEPTH)
  ) u_tag_pipe (
    .clk          (clk),
    .rst_n        (rst_n),
    .push_valid   (push_valid_c),
    .push_owner   (push_owner_c),
    .flush        (flush),
    .tail_valid_c (tail_valid_c),
    .tail_owner_c (tail_owner_c)
  );

  assign if_rvalid = tail_valid_c & (tail_owner_c == OWN_IF);
  assign dm_rvalid = tail_valid_c & (tail_owner_c == OWN_DM);
  assign if_rdata  = if_rvalid ? mem_rdata : '0;
  assign dm_rdata  = dm_rvalid ? mem_rdata : '0;

`ifdef ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_if_grants <= '0;
      stat_dm_grants <= '0;
      stat_conflicts <= '0;
    end else begin
      if (if_gnt && (stat_if_grants != '1)) stat_if_grants <= stat_if_grants + 32'd1;
      if (dm_gnt && (stat_dm_grants != '1)) stat_dm_grants <= stat_dm_grants + 32'd1;
      if (if_req && dm_req && (stat_conflicts != '1)) stat_conflicts <= stat_conflicts + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized scoreboard bench for mem_port_arbiter against a transaction-level model.
module tb_mem_port_arbiter;

  localparam int unsigned AW         = 10;
  localparam int unsigned DW         = 32;
  localparam int unsigned RD_LAT     = 2;
  localparam int unsigned STARVE_MAX = 4;
  localparam int unsigned MEM_WORDS  = 1 << AW;

  logic          clk, rst_n;
  logic          if_req, dm_req, dm_we, flush;
  logic [AW-1:0] if_addr, dm_addr;
  logic [DW-1:0] dm_wdata;
  logic          if_gnt, if_rvalid, dm_gnt, dm_rvalid;
  logic [DW-1:0] if_rdata, dm_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
`ifdef ARB_STATS_EN
  logic [31:0]   stat_if_grants, stat_dm_grants, stat_conflicts;
`endif

  mem_port_arbiter #(
    .AW(AW), .DW(DW), .RD_LAT(RD_LAT), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .flush(flush),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef ARB_STATS_EN
    , .stat_if_grants(stat_if_grants), .stat_dm_grants(stat_dm_grants),
    .stat_conflicts(stat_conflicts)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;

  function automatic void check(input bit ok, input string nm,
                                input logic [31:0] act, input logic [31:0] want);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s t=%0t cyc=%0d actual=%h expected=%h", nm, $time, cyc, act, want);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Memory array environment with RD_LAT read latency; junk when no read.
  logic [DW-1:0] env_mem [MEM_WORDS];
  logic [DW-1:0] rd_pipe [RD_LAT];
  always @(posedge clk) begin
    if (mem_en && mem_we) env_mem[mem_addr] = mem_wdata;
    rd_pipe[0] <= (mem_en && !mem_we) ? env_mem[mem_addr] : DW'($urandom);
    for (int i = 1; i < int'(RD_LAT); i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_rdata = rd_pipe[RD_LAT-1];

  // Reference model: arbitration rules, shadow memory and expected responses.
  typedef struct { int due; logic [DW-1:0] data; } rsp_t;
  rsp_t          ifq[$];
  rsp_t          dmq[$];
  logic [DW-1:0] ref_mem [MEM_WORDS];
  int            losses;
  bit            m_if_gnt, m_dm_gnt;
  int            m_if_cnt, m_dm_cnt, m_conf_cnt;

  always @(negedge clk) begin
    bit e_if, e_dm;
    logic [AW-1:0] e_addr;
    if (!rst_n) begin
      ifq.delete(); dmq.delete();
      losses = 0; m_if_gnt = 0; m_dm_gnt = 0;
      m_if_cnt = 0; m_dm_cnt = 0; m_conf_cnt = 0;
    end else begin
      e_if   = if_req && !flush && (!dm_req || losses >= int'(STARVE_MAX));
      e_dm   = dm_req && !e_if;
      e_addr = e_dm ? dm_addr : (e_if ? if_addr : '0);
      check(if_gnt == e_if, "if_gnt", 32'(if_gnt), 32'(e_if));
      check(dm_gnt == e_dm, "dm_gnt", 32'(dm_gnt), 32'(e_dm));
      check(mem_en == (e_if || e_dm), "mem_en", 32'(mem_en), 32'(e_if || e_dm));
      check(mem_we == (e_dm && dm_we), "mem_we", 32'(mem_we), 32'(e_dm && dm_we));
      check(mem_addr == e_addr, "mem_addr", 32'(mem_addr), 32'(e_addr));
      if (!e_if) check(mem_wdata == (e_dm ? dm_wdata : '0), "mem_wdata",
                       mem_wdata, e_dm ? dm_wdata : '0);
      if (flush) ifq.delete();
      if (e_if) ifq.push_back('{due: cyc + int'(RD_LAT), data: ref_mem[if_addr]});
      if (e_dm && !dm_we) dmq.push_back('{due: cyc + int'(RD_LAT), data: ref_mem[dm_addr]});
      if (e_dm && dm_we) ref_mem[dm_addr] = dm_wdata;
      losses = (if_req && !e_if && !flush) ? losses + 1 : 0;
      if (e_if) m_if_cnt++;
      if (e_dm) m_dm_cnt++;
      if (if_req && dm_req) m_conf_cnt++;
      m_if_gnt = e_if;
      m_dm_gnt = e_dm;
    end
  end

  task automatic check_port(input bit is_dm, input logic vld, input logic [DW-1:0] dat);
    bit   has, exp_v;
    rsp_t head;
    head = '{due: -1, data: '0};
    has  = is_dm ? (dmq.size() != 0) : (ifq.size() != 0);
    if (has) begin
      if (is_dm) head = dmq[0];
      else head = ifq[0];
    end
    exp_v = has && (head.due == cyc);
    check(vld == exp_v, is_dm ? "dm_rvalid" : "if_rvalid", 32'(vld), 32'(exp_v));
    if (exp_v) begin
      if (is_dm) void'(dmq.pop_front());
      else void'(ifq.pop_front());
      if (vld) check(dat == head.data, is_dm ? "dm_rdata" : "if_rdata", dat, head.data);
    end else begin
      check(dat == '0, is_dm ? "dm_rdata_idle" : "if_rdata_idle", dat, '0);
    end
  endtask

  // Monitor: runs after the model has applied this cycle's flush.
  always @(negedge clk) begin
    #1;
    if (rst_n) begin
      check_port(1'b0, if_rvalid, if_rdata);
      check_port(1'b1, dm_rvalid, dm_rdata);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic ir, input logic [AW-1:0] ia, input logic dr,
                        input logic dw, input logic [AW-1:0] da,
                        input logic [DW-1:0] dwd, input logic fl);
    if_req = ir; if_addr = ia; dm_req = dr; dm_we = dw;
    dm_addr = da; dm_wdata = dwd; flush = fl;
  endtask

  task automatic idle(input int n);
    set_in(0, '0, 0, 0, '0, '0, 0);
    repeat (n) tick();
  endtask

  task automatic rand_cycle();
    if (!if_req || m_if_gnt) begin
      if_req  = ($urandom_range(3) != 0);
      if_addr = AW'($urandom);
    end
    if (!dm_req || m_dm_gnt) begin
      dm_req   = ($urandom_range(1) == 1);
      dm_we    = ($urandom_range(2) == 0);
      dm_addr  = AW'($urandom_range(63));
      dm_wdata = DW'($urandom);
    end
    flush = ($urandom_range(7) == 0);
    tick();
  endtask

  initial begin
    int n_if, n_dm, n_dbl;
    logic [DW-1:0] v;
    for (int i = 0; i < int'(MEM_WORDS); i++) begin
      v = DW'($urandom);
      ref_mem[i] = v;
      env_mem[i] = v;
    end
    rst_n = 1'b0;
    set_in(0, '0, 0, 0, '0, '0, 0);
    repeat (2) tick();

    // Reset state, with both requests asserted
    set_in(1, 10'd3, 1, 0, 10'd4, 32'h1234_5678, 0);
    #1;
    check(if_gnt == 1'b0, "rst_if_gnt", 32'(if_gnt), 0);
    check(dm_gnt == 1'b0, "rst_dm_gnt", 32'(dm_gnt), 0);
    check(mem_en == 1'b0, "rst_mem_en", 32'(mem_en), 0);
    check(mem_we == 1'b0, "rst_mem_we", 32'(mem_we), 0);
    check(mem_addr == '0, "rst_mem_addr", 32'(mem_addr), 0);
    check(mem_wdata == '0, "rst_mem_wdata", mem_wdata, 0);
    check(if_rvalid == 1'b0, "rst_if_rvalid", 32'(if_rvalid), 0);
    check(dm_rvalid == 1'b0, "rst_dm_rvalid", 32'(dm_rvalid), 0);
    check(if_rdata == '0, "rst_if_rdata", if_rdata, 0);
    check(dm_rdata == '0, "rst_dm_rdata", dm_rdata, 0);
    tick();
    rst_n = 1'b1;
    idle(2);

    // IF-only fetch from address 5
    set_in(1, 10'd5, 0, 0, '0, '0, 0);
    tick();
    idle(3);

    // DM store to address 12, then load it back
    set_in(0, '0, 1, 1, 10'd12, 32'hDEAD_BEEF, 0);
    tick();
    set_in(0, '0, 1, 0, 10'd12, '0, 0);
    tick();
    idle(3);

    // Continuous contention: four DM grants then one IF grant, repeating
    n_if = 0; n_dm = 0; n_dbl = 0;
    for (int i = 0; i < 10; i++) begin
      set_in(1, 10'd7, 1, 0, AW'(i + 100), '0, 0);
      @(negedge clk);
      n_if += int'(if_gnt);
      n_dm += int'(dm_gnt);
      n_dbl += int'(if_gnt && dm_gnt);
      tick();
    end
    check(n_dm == 8, "contest_dm_grants", 32'(n_dm), 8);
    check(n_if == 2, "contest_if_grants", 32'(n_if), 2);
    check(n_dbl == 0, "contest_double_grant", 32'(n_dbl), 0);
    idle(3);

    // Fetch in flight, then DM load alongside a flush
    set_in(1, 10'd33, 0, 0, '0, '0, 0);
    tick();
    set_in(0, '0, 1, 0, 10'd44, '0, 1);
    tick();
    idle(4);

    // Asynchronous reset with reads in flight
    set_in(1, 10'd100, 0, 0, '0, '0, 0);
    tick();
    set_in(0, '0, 1, 0, 10'd200, '0, 0);
    tick();
    set_in(1, 10'd101, 1, 0, 10'd201, '0, 0);
    #1;
    check(if_rvalid == 1'b1, "pre_rst_if_rvalid", 32'(if_rvalid), 1);
    rst_n = 1'b0;
    #1;
    check(if_gnt == 1'b0, "async_rst_if_gnt", 32'(if_gnt), 0);
    check(dm_gnt == 1'b0, "async_rst_dm_gnt", 32'(dm_gnt), 0);
    check(mem_en == 1'b0, "async_rst_mem_en", 32'(mem_en), 0);
    check(if_rvalid == 1'b0, "async_rst_if_rvalid", 32'(if_rvalid), 0);
    check(dm_rvalid == 1'b0, "async_rst_dm_rvalid", 32'(dm_rvalid), 0);
    check(if_rdata == '0, "async_rst_if_rdata", if_rdata, 0);
    tick();
    set_in(0, '0, 0, 0, '0, '0, 0);
    rst_n = 1'b1;
    idle(4);
    for (int i = 0; i < 6; i++) begin
      set_in(1, 10'd9, 1, 0, AW'(i), '0, 0);
      tick();
    end
    idle(2);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) rand_cycle();
    idle(RD_LAT + 4);

    check(ifq.size() == 0, "if_rsp_outstanding", 32'(ifq.size()), 0);
    check(dmq.size() == 0, "dm_rsp_outstanding", 32'(dmq.size()), 0);
`ifdef ARB_STATS_EN
    check(stat_if_grants == 32'(m_if_cnt), "stat_if_grants", stat_if_grants, 32'(m_if_cnt));
    check(stat_dm_grants == 32'(m_dm_cnt), "stat_dm_grants", stat_dm_grants, 32'(m_dm_cnt));
    check(stat_conflicts == 32'(m_conf_cnt), "stat_conflicts", stat_conflicts, 32'(m_conf_cnt));
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
